// File: rtl/abr_prim_util_pkg.sv
// Shared primitive utilities: width helpers used to size counters and pointers.
package abr_prim_util_pkg;

  // Bits needed to index 'value' distinct items; never less than 1.
  function automatic int unsigned vbits(int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/abr_prim_fifo_ptr.sv
// Wrap-bit pointer counter: index runs 0..Depth-1, wrap toggles on rollover,
// so equal indices with differing wrap bits distinguish full from empty.
module abr_prim_fifo_ptr #(
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PtrW-1:0] ptr_o,
  output logic            wrap_o
);

  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

  logic [PtrW-1:0] ptr_d, ptr_q;
  logic            wrap_d, wrap_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ptr_d  = ptr_q;
    wrap_d = wrap_q;
    if (clr_i) begin
      ptr_d  = '0;
      wrap_d = 1'b0;
    end else if (inc_i) begin
      if (ptr_q == LastIdx) begin
        ptr_d  = '0;
        wrap_d = ~wrap_q;
      end else begin
        ptr_d = ptr_q + PtrW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/abr_prim_fifo_sync.sv
// Single-clock valid/ready FIFO with non-power-of-2 depth support, optional
// fall-through when empty, synchronous flush and a pointer integrity flag.
module abr_prim_fifo_sync
  import abr_prim_util_pkg::*;
#(
  parameter  int unsigned Width  = 32,
  parameter  int unsigned Depth  = 4,
  parameter  bit          Pass   = 1'b1,
  localparam int unsigned PtrW   = vbits(Depth),
  localparam int unsigned DepthW = vbits(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o,
  output logic              err_o
);

  if (Depth == 0) begin : gen_depth_check
    $error("abr_prim_fifo_sync: Depth must be at least 1");
  end

  // One spare bit so a corrupted pointer pair shows up as a count above Depth.
  localparam int unsigned CntW = DepthW + 1;

  logic            init_d, init_q;
  logic [PtrW-1:0] widx, ridx;
  logic            wwrap, rwrap;
  logic            empty, full;
  logic            push, pop, bypass;
  logic [CntW-1:0] count;
  logic [Width-1:0] mem_q [Depth];

  assign init_d = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q <= 1'b0;
    end else begin
      init_q <= init_d;
    end
  end

  abr_prim_fifo_ptr #(.Depth(Depth), .PtrW(PtrW)) u_wptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (push),
    .ptr_o  (widx),
    .wrap_o (wwrap)
  );

  abr_prim_fifo_ptr #(.Depth(Depth), .PtrW(PtrW)) u_rptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (pop),
    .ptr_o  (ridx),
    .wrap_o (rwrap)
  );

  assign empty = (widx == ridx) && (wwrap == rwrap);
  assign full  = (widx == ridx) && (wwrap != rwrap);

  always_comb begin
    count = '0;
    if (wwrap == rwrap) begin
      count = CntW'(widx) - CntW'(ridx);
    end else begin
      count = CntW'(Depth) - CntW'(ridx) + CntW'(widx);
    end
  end

  assign wready_o = init_q & ~full & ~clr_i;
  assign rvalid_o = init_q & ~clr_i & (~empty | (Pass & wvalid_i));

  // A word forwarded to a ready reader never touches storage or the pointers.
  assign bypass = Pass & empty & wvalid_i & rready_i & init_q & ~clr_i;
  assign push   = wvalid_i & wready_o & ~bypass;
  assign pop    = rvalid_o & rready_i & ~empty;

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing the data would only cost reset routing.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[widx] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (rvalid_o) begin
      rdata_o = empty ? wdata_i : mem_q[ridx];
    end
  end

  assign full_o  = full;
  assign depth_o = count[DepthW-1:0];
  assign err_o   = (count > CntW'(Depth));

endmodule
